// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
// Bundles every handshake/bus signal of the instruction fetch unit.
//   imem_req_*   : request channel to instruction memory (valid/ready, address)
//   imem_rsp_*   : in-order response channel from instruction memory
//   redirect_*   : branch/jump redirect from the back end
//   halt_req     : request to quiesce fetching; halted reports it is done
//   out_*        : instruction stream to decode (valid/ready, pc, instr)
// Modports:
//   master : the fetch unit side
//   slave  : the environment side (memory, back end, decode)
// -----------------------------------------------------------------------------
interface instr_fetch_if #(
   parameter int XLEN = 32
);
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [31:0]     imem_rsp_data;

   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            halt_req;
   logic            halted;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [31:0]     out_instr;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid, imem_rsp_data,
      input  redirect_valid, redirect_pc, halt_req,
      output halted,
      output out_valid, out_pc, out_instr,
      input  out_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid, imem_rsp_data,
      output redirect_valid, redirect_pc, halt_req,
      input  halted,
      input  out_valid, out_pc, out_instr,
      output out_ready
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Sequential instruction fetcher with a credit-limited request stream, an
// in-flight address FIFO, a {pc, instr} queue towards decode, redirect
// flushing with stale-response dropping, and a RUN/DRAIN/HALTED halt FSM.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : instr_fetch_if.master (imem request/response, redirect, halt,
//           decode-side output stream)
// Parameters:
//   XLEN     : PC / address width
//   QDEPTH   : queue depth and in-flight limit (power of 2, >= 2)
//   RESET_PC : first fetch address after reset
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter int              XLEN     = 32,
   parameter int              QDEPTH   = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic           clk,
   input  logic           reset,
   instr_fetch_if.master  bus
);
   localparam int AW = $clog2(QDEPTH);
   localparam int CW = $clog2(QDEPTH + 1);
   localparam logic [CW:0] DEPTH_C = (CW+1)'(QDEPTH);

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_DRAIN  = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   logic [1:0]      state;
   logic [XLEN-1:0] fetch_pc;

   // Decode-side queue of fetched {pc, instr}
   logic [XLEN-1:0] q_pc    [QDEPTH];
   logic [31:0]     q_instr [QDEPTH];
   logic [AW-1:0]   q_rd, q_wr;
   logic [CW-1:0]   q_cnt;

   // Addresses of requests still waiting for their response
   logic [XLEN-1:0] fl_addr [QDEPTH];
   logic [AW-1:0]   fl_rd, fl_wr;
   logic [CW-1:0]   inflight;
   logic [CW-1:0]   drop_cnt;

   logic            req_fire, rsp_take, q_push, q_pop;
   logic [CW-1:0]   inflight_next;

   // Credit rule: queued entries plus outstanding requests never exceed
   // QDEPTH, so every response is guaranteed a queue slot.
   assign bus.imem_req_valid = reset && (state == ST_RUN) && !bus.redirect_valid &&
                               (({1'b0, q_cnt} + {1'b0, inflight}) < DEPTH_C);
   assign bus.imem_req_addr  = fetch_pc;

   assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
   // A response with nothing outstanding is a protocol error (e.g. a late
   // response to a request abandoned by reset) and is ignored.
   assign rsp_take = bus.imem_rsp_valid && (inflight != '0);
   assign q_push   = rsp_take && (drop_cnt == '0) && !bus.redirect_valid;
   assign q_pop    = bus.out_valid && bus.out_ready && !bus.redirect_valid;

   assign inflight_next = inflight + CW'(req_fire) - CW'(rsp_take);

   assign bus.out_valid = (q_cnt != '0);
   assign bus.out_pc    = bus.out_valid ? q_pc[q_rd]    : '0;
   assign bus.out_instr = bus.out_valid ? q_instr[q_rd] : '0;
   assign bus.halted    = (state == ST_HALTED);

   // NOTE: storage arrays carry no reset; validity is tracked by the
   // counters/pointers, and the output mux forces zeros while empty.
   always_ff @(posedge clk) begin
      if (req_fire) fl_addr[fl_wr] <= fetch_pc;
      if (q_push) begin
         q_pc[q_wr]    <= fl_addr[fl_rd];
         q_instr[q_wr] <= bus.imem_rsp_data;
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_RUN;
         fetch_pc <= RESET_PC;
         q_rd     <= '0;
         q_wr     <= '0;
         q_cnt    <= '0;
         fl_rd    <= '0;
         fl_wr    <= '0;
         inflight <= '0;
         drop_cnt <= '0;
      end else begin
         // The in-flight FIFO tracks the memory protocol and is never flushed.
         inflight <= inflight_next;
         if (req_fire) fl_wr <= fl_wr + 1'b1;
         if (rsp_take) fl_rd <= fl_rd + 1'b1;

         if (bus.redirect_valid) begin
            // Everything still outstanding (including a same-cycle handshake,
            // minus a same-cycle response) belongs to the old path.
            fetch_pc <= bus.redirect_pc & ~XLEN'(3);
            q_rd     <= '0;
            q_wr     <= '0;
            q_cnt    <= '0;
            drop_cnt <= inflight_next;
         end else begin
            if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
            if (rsp_take && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
            if (q_push) q_wr <= q_wr + 1'b1;
            if (q_pop)  q_rd <= q_rd + 1'b1;
            if (q_push && !q_pop)      q_cnt <= q_cnt + 1'b1;
            else if (!q_push && q_pop) q_cnt <= q_cnt - 1'b1;
         end

         case (state)
            ST_RUN:    if (bus.halt_req) state <= ST_DRAIN;
            ST_DRAIN: begin
               if (!bus.halt_req)         state <= ST_RUN;
               else if (inflight == '0)   state <= ST_HALTED;
            end
            ST_HALTED: if (!bus.halt_req) state <= ST_RUN;
            default:                      state <= ST_RUN;
         endcase
      end
   end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Drives instr_fetch_unit with an in-order memory model of configurable
// latency and checks the decode stream against a reference: outputs form a
// contiguous PC sequence starting at RESET_PC or the latest redirect target,
// each carrying the instruction word the memory holds at that address.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;
   localparam logic [31:0] RST_PC = 32'h100;
   localparam int          QD     = 4;

   logic clk;
   logic reset;

   instr_fetch_if #(.XLEN(32)) bus ();

   instr_fetch_unit #(.XLEN(32), .QDEPTH(QD), .RESET_PC(RST_PC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // memory model
   logic [31:0] mem_q   [$];
   int          mem_due [$];
   int          mem_lat   = 1;
   int          last_due  = 0;
   bit          mem_hold  = 0;
   bit          rand_ready = 0;

   // per-cycle samples and bookkeeping
   int          cyc = 0;
   logic        s_req_valid, s_hs, s_out_valid, s_pop, s_halted;
   logic [31:0] s_addr, s_out_pc, s_out_instr;
   int          hs_cnt = 0;
   int          pop_cnt = 0;
   logic [31:0] pop_pc  [$];
   int          pop_cyc [$];
   logic [31:0] exp_pc = RST_PC;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
   endfunction

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // One clock cycle: called at a negedge with control inputs already set.
   task automatic tick();
      int due;
      if (!mem_hold && mem_q.size() != 0 && mem_due[0] <= cyc) begin
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = instr_of(mem_q.pop_front());
         void'(mem_due.pop_front());
      end else begin
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = $urandom;
      end
      if (rand_ready) bus.imem_req_ready = ($urandom_range(0, 3) != 0);
      #1;
      s_req_valid = bus.imem_req_valid;
      s_addr      = bus.imem_req_addr;
      s_hs        = bus.imem_req_valid && bus.imem_req_ready;
      s_out_valid = bus.out_valid;
      s_out_pc    = bus.out_pc;
      s_out_instr = bus.out_instr;
      s_halted    = bus.halted;
      s_pop       = bus.out_valid && bus.out_ready && !bus.redirect_valid && reset;

      if (!reset) exp_pc = RST_PC;
      if (s_halted) check("halted_no_req", s_req_valid, 1'b0);
      if (s_pop) begin
         check("out_pc", s_out_pc, exp_pc);
         check("out_instr", s_out_instr, instr_of(exp_pc));
         pop_pc.push_back(s_out_pc);
         pop_cyc.push_back(cyc);
         pop_cnt++;
         exp_pc = exp_pc + 32'd4;
      end
      if (bus.redirect_valid && reset) exp_pc = bus.redirect_pc & ~32'h3;
      if (s_hs) begin
         due = cyc + mem_lat;
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         mem_q.push_back(s_addr);
         mem_due.push_back(due);
         hs_cnt++;
         check("credit_limit", mem_q.size() <= QD, 1'b1);
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   // Stop issuing, let memory and queue empty, then pulse reset.
   task automatic quiesce();
      rand_ready          = 0;
      bus.imem_req_ready  = 1'b0;
      bus.out_ready       = 1'b1;
      bus.redirect_valid  = 1'b0;
      bus.halt_req        = 1'b0;
      mem_hold            = 0;
      repeat (12) tick();
      check("quiesce_mem_empty", mem_q.size(), 0);
      reset = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int rel, h0, p0, pstart;
      bit found;

      reset              = 1'b0;
      bus.imem_req_ready = 1'b1;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.halt_req       = 1'b0;
      bus.out_ready      = 1'b1;
      @(negedge clk);

      // Reset state
      tick();
      check("rst_req_valid", s_req_valid, 1'b0);
      check("rst_out_valid", s_out_valid, 1'b0);
      check("rst_halted",    s_halted,    1'b0);
      check("rst_out_pc",    s_out_pc,    32'h0);
      check("rst_out_instr", s_out_instr, 32'h0);
      tick();

      // First request right after release, then zero-wait streaming
      reset   = 1'b1;
      mem_lat = 1;
      rel     = cyc;
      tick();
      check("first_req_valid", s_req_valid, 1'b1);
      check("first_req_addr",  s_addr,      RST_PC);
      repeat (7) tick();
      check("stream_pc0", pop_pc[0], 32'h100);
      check("stream_pc1", pop_pc[1], 32'h104);
      check("stream_pc2", pop_pc[2], 32'h108);
      check("stream_latency", pop_cyc[0] - rel, 2);
      check("stream_rate01", pop_cyc[1] - pop_cyc[0], 1);
      check("stream_rate12", pop_cyc[2] - pop_cyc[1], 1);
      quiesce();

      // Back-pressure: fill to QDEPTH, one pop frees exactly one credit
      bus.out_ready = 1'b0;
      bus.imem_req_ready = 1'b1;
      h0 = hs_cnt;
      repeat (12) tick();
      check("fill_hs_count", hs_cnt - h0, QD);
      check("fill_req_stall", s_req_valid, 1'b0);
      check("fill_out_valid", s_out_valid, 1'b1);
      bus.out_ready = 1'b1;
      p0 = pop_cnt;
      tick();
      bus.out_ready = 1'b0;
      check("single_pop", pop_cnt - p0, 1);
      tick();
      check("refill_req", s_req_valid, 1'b1);
      repeat (4) tick();
      check("refill_hs_count", hs_cnt - h0, QD + 1);
      quiesce();

      // Redirect with 2 in flight and 1 queued
      bus.imem_req_ready = 1'b1;
      bus.out_ready      = 1'b0;
      mem_hold           = 1;
      repeat (3) tick();
      bus.imem_req_ready = 1'b0;
      mem_hold           = 0;
      tick();
      mem_hold           = 1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h203;
      tick();
      check("redir_no_req", s_req_valid, 1'b0);
      bus.redirect_valid = 1'b0;
      mem_hold           = 0;
      bus.imem_req_ready = 1'b1;
      bus.out_ready      = 1'b1;
      p0 = pop_cnt;
      tick();
      check("redir_addr", s_addr, 32'h200);
      check("redir_flushed", s_out_valid, 1'b0);
      repeat (10) tick();
      check("redir_first_pc", pop_pc[p0], 32'h200);
      quiesce();

      // Halt with 3 in flight and 2-cycle latency
      bus.imem_req_ready = 1'b1;
      bus.out_ready      = 1'b1;
      mem_lat            = 2;
      mem_hold           = 1;
      repeat (3) tick();
      bus.imem_req_ready = 1'b0;
      bus.halt_req       = 1'b1;
      mem_hold           = 0;
      pstart = pop_cnt;
      tick();
      bus.imem_req_ready = 1'b1;
      h0 = hs_cnt;
      for (int i = 0; i < 20 && !s_halted; i++) tick();
      check("halt_reached", s_halted, 1'b1);
      check("halt_no_hs", hs_cnt - h0, 0);
      check("halt_drained", pop_cnt - pstart, 3);
      repeat (3) tick();
      check("halt_hold_no_hs", hs_cnt - h0, 0);
      bus.halt_req = 1'b0;
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick();
         if (s_hs) found = 1;
      end
      check("resume_seen", found, 1'b1);
      check("resume_addr", s_addr, 32'h10C);
      quiesce();

      // Address wrap at the top of the address space
      mem_lat = 1;
      bus.imem_req_ready = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'hFFFF_FFFC;
      tick();
      bus.redirect_valid = 1'b0;
      tick();
      check("wrap_addr0", s_addr, 32'hFFFF_FFFC);
      tick();
      check("wrap_addr1", s_addr, 32'h0);
      repeat (6) tick();
      quiesce();

      // Reset mid-flight, late responses must be ignored
      bus.imem_req_ready = 1'b1;
      mem_hold           = 1;
      repeat (2) tick();
      reset = 1'b0;
      tick();
      check("midrst_req_valid", s_req_valid, 1'b0);
      check("midrst_out_valid", s_out_valid, 1'b0);
      bus.imem_req_ready = 1'b0;
      tick();
      reset    = 1'b1;
      mem_hold = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("late_rsp_out_valid", s_out_valid, 1'b0);
      end
      check("late_rsp_consumed", mem_q.size(), 0);
      bus.imem_req_ready = 1'b1;
      tick();
      check("post_rst_hs", s_hs, 1'b1);
      check("post_rst_addr", s_addr, RST_PC);
      quiesce();

      // Randomized traffic: latency, ready, back-pressure, redirects, halts
      rand_ready = 1;
      for (int i = 0; i < 1500; i++) begin
         mem_lat            = $urandom_range(1, 4);
         bus.out_ready      = ($urandom_range(0, 3) != 0);
         bus.redirect_valid = ($urandom_range(0, 31) == 0);
         bus.redirect_pc    = $urandom;
         if ($urandom_range(0, 49) == 0) bus.halt_req = ~bus.halt_req;
         tick();
      end
      quiesce();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL expose parameter XLEN, default 32, meaning the PC and address width (>=32).
REQ-002 The block SHALL expose parameter QDEPTH, default 4, meaning fetch-queue depth and in-flight limit (power of 2, >=2).
REQ-003 The block SHALL expose parameter RESET_PC, default 0, meaning the first fetch address after reset.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset: clk input 1 (rising-edge clock); reset input 1 (asynchronous, active-low).
REQ-005 The block SHALL have the following imem ports: imem_req_valid output 1 (request); imem_req_ready input 1 (memory accepts); imem_req_addr output XLEN (word address); imem_rsp_valid input 1 (response, in order); imem_rsp_data input 32 (instruction word).
REQ-006 The block SHALL have the following control ports: redirect_valid input 1 (branch/jump redirect); redirect_pc input XLEN (new PC); halt_req input 1 (stop fetching); halted output 1 (fetch quiesced).
REQ-007 The block SHALL have the following decode-side ports: out_valid output 1; out_ready input 1; out_pc output XLEN; out_instr output 32.

Function
REQ-008 The block SHALL hold fetch_pc, a queue of {pc, instr} (QDEPTH entries), an in-flight address FIFO (QDEPTH entries), and counters q_cnt, inflight, and drop_cnt, each 0..QDEPTH.
REQ-009 imem_req_valid SHALL be 1 iff state is RUN, redirect_valid is 0, and q_cnt+inflight < QDEPTH; it SHALL be a function of registered state and redirect_valid only.
REQ-010 imem_req_addr SHALL equal fetch_pc; on a handshake (req_valid & req_ready), fetch_pc SHALL advance by 4 modulo 2^XLEN, the address SHALL be pushed to the in-flight FIFO, and inflight SHALL increment.
REQ-011 A response SHALL pop the in-flight FIFO and decrement inflight; if drop_cnt>0, the response SHALL be discarded and drop_cnt decremented, otherwise {address, imem_rsp_data} SHALL be pushed to the queue.
REQ-012 A queued response SHALL be visible on out_* the cycle after imem_rsp_valid, giving one cycle of latency with no bypass.
REQ-013 out_valid SHALL be (q_cnt!=0); out_pc and out_instr SHALL show the queue head; a pop SHALL occur on out_valid & out_ready.
REQ-014 Push and pop in the same cycle SHALL leave q_cnt unchanged, including at q_cnt==QDEPTH; the credit rule in REQ-009 SHALL make overflow impossible.
REQ-015 A response with inflight==0 is a protocol error and SHALL be ignored without changing state.
REQ-016 On redirect_valid: fetch_pc SHALL become {redirect_pc[XLEN-1:2],2'b00}, the queue SHALL be cleared, and no pop SHALL occur that cycle.
REQ-017 On redirect_valid, drop_cnt SHALL become inflight plus any same-cycle handshake minus any same-cycle response; a response arriving in the redirect cycle SHALL be discarded.
REQ-018 Redirect SHALL take priority over push, pop, and the halt transitions for fetch_pc and queue state.
REQ-019 The FSM SHALL have three states: RUN, DRAIN, and HALTED.
REQ-020 In RUN, halt_req=1 SHALL cause a transition to DRAIN.
REQ-021 In DRAIN, no requests SHALL issue; when inflight==0 the FSM SHALL go to HALTED; if halt_req=0 it SHALL return to RUN.
REQ-022 In HALTED, halted SHALL be 1 and no requests SHALL issue; halt_req=0 SHALL cause a transition to RUN; a redirect SHALL update fetch_pc and clear the queue while the FSM stays HALTED.
REQ-023 The queue SHALL still drain to decode in DRAIN and HALTED.

Reset
REQ-024 While reset=0, the block SHALL hold: fetch_pc=RESET_PC, q_cnt=inflight=drop_cnt=0, FIFO pointers=0, state=RUN, imem_req_valid=0, out_valid=0, halted=0, out_pc=0, out_instr=0.
REQ-025 Reset asserted mid-operation SHALL abandon all in-flight requests; responses to them arriving after reset release SHALL be ignored via REQ-015.
REQ-026 imem_req_valid SHALL assert in the first cycle after reset deasserts, with addr=RESET_PC.

Verification
REQ-027 Zero-wait memory (req_ready=1, rsp the next cycle), out_ready=1, RESET_PC=0x100 -> out_pc sequence 0x100,0x104,0x108, one instruction per cycle after fill.
REQ-028 out_ready=0 held, QDEPTH=4 -> exactly 4 handshakes, then req_valid=0, q_cnt=4; with out_ready=1 for one cycle -> one pop, then one new request.
REQ-029 Redirect to 0x203 with 2 in flight and 1 queued -> queue empty, drop_cnt=2, next req_addr=0x200, the 2 stale responses are never output, and the first out_pc is 0x200.
REQ-030 halt_req=1 with 3 in flight and 2-cycle response latency -> no new requests, halted=1 after the last response, and all queued entries still delivered; halt_req=0 -> fetch resumes at the next sequential PC.
REQ-031 fetch_pc=0xFFFFFFFC (XLEN=32) -> next req_addr=0x00000000.
REQ-032 Reset pulsed low with 2 in flight, then 2 late responses -> out_valid stays 0, and the first request after release is RESET_PC.
